// File: rtl/multicycle_main_control.sv
// rtl/multicycle_main_control.sv - multicycle MIPS main control FSM producing ALUOp class and datapath strobes
// Optional performance counters are enabled by defining CTRL_PERF_CNT_EN.
module multicycle_main_control #(
    parameter bit ILLEGAL_HALT = 1'b0
`ifdef CTRL_PERF_CNT_EN
    , parameter int COUNT_W = 32
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [3:0] ALUOp,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       reg_write,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       alu_src,
    output logic [2:0] state_out,
`ifdef CTRL_PERF_CNT_EN
    output logic [COUNT_W-1:0] instr_retired,
    output logic [COUNT_W-1:0] stall_cycles,
`endif
    output logic       illegal_op
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        BRANCH = 3'd5,
        JUMP   = 3'd6,
        HALT   = 3'd7
    } state_t;

    state_t state, next_state;

    logic is_rtype, is_jr, is_addi, is_andi, is_ori, is_lui;
    logic is_lw, is_sw, is_beq, is_bne, is_j, is_jal;
    logic is_exec_class;
    logic [3:0] class_aluop;

    assign is_rtype = (opcode == 6'b000000);
    assign is_jr    = is_rtype && (funct == 6'b001000);
    assign is_addi  = (opcode == 6'b001000);
    assign is_andi  = (opcode == 6'b001100);
    assign is_ori   = (opcode == 6'b001101);
    assign is_lui   = (opcode == 6'b001111);
    assign is_lw    = (opcode == 6'b100011);
    assign is_sw    = (opcode == 6'b101011);
    assign is_beq   = (opcode == 6'b000100);
    assign is_bne   = (opcode == 6'b000101);
    assign is_j     = (opcode == 6'b000010);
    assign is_jal   = (opcode == 6'b000011);

    assign is_exec_class = (is_rtype && !is_jr) || is_addi || is_andi || is_ori
                         || is_lui || is_lw || is_sw;

    // Class code is a pure function of the opcode held in IR; gated by state below.
    always_comb begin
        class_aluop = 4'b0000;
        if (is_rtype)     class_aluop = 4'b0111;
        else if (is_addi) class_aluop = 4'b0100;
        else if (is_andi) class_aluop = 4'b0101;
        else if (is_ori)  class_aluop = 4'b0110;
        else if (is_lui)  class_aluop = 4'b0011;
        else if (is_beq)  class_aluop = 4'b1000;
        else if (is_bne)  class_aluop = 4'b1001;
        else if (is_lw)   class_aluop = 4'b1010;
        else if (is_sw)   class_aluop = 4'b1011;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= FETCH;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        ALUOp      = 4'b0000;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'b00;
        reg_write  = 1'b0;
        reg_dst    = 2'b00;
        mem_to_reg = 2'b00;
        alu_src    = 1'b0;
        illegal_op = 1'b0;

        case (state)
            FETCH: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    next_state = DECODE;
                end
            end
            DECODE: begin
                if (is_jr)              next_state = JUMP;
                else if (is_exec_class) next_state = EXEC;
                else if (is_beq || is_bne) next_state = BRANCH;
                else if (is_j || is_jal)   next_state = JUMP;
                else begin
                    illegal_op = 1'b1;
                    next_state = ILLEGAL_HALT ? HALT : FETCH;
                end
            end
            EXEC: begin
                ALUOp      = class_aluop;
                alu_src    = !is_rtype;
                next_state = (is_lw || is_sw) ? MEM : WB;
            end
            MEM: begin
                ALUOp     = class_aluop;
                alu_src   = 1'b1;
                mem_read  = is_lw;
                mem_write = is_sw;
                if (mem_ready) next_state = is_lw ? WB : FETCH;
            end
            WB: begin
                ALUOp      = class_aluop;
                reg_write  = 1'b1;
                reg_dst    = is_rtype ? 2'b01 : 2'b00;
                mem_to_reg = is_lw ? 2'b01 : 2'b00;
                next_state = FETCH;
            end
            BRANCH: begin
                ALUOp      = class_aluop;
                pc_src     = 2'b01;
                pc_write   = (is_beq && zero) || (is_bne && !zero);
                next_state = FETCH;
            end
            JUMP: begin
                pc_write = 1'b1;
                if (is_jr) begin
                    pc_src = 2'b11;
                end else begin
                    pc_src = 2'b10;
                    if (is_jal) begin
                        reg_write  = 1'b1;
                        reg_dst    = 2'b10;
                        mem_to_reg = 2'b10;
                    end
                end
                next_state = FETCH;
            end
            HALT: next_state = HALT;
            default: next_state = FETCH;
        endcase

        // Reset overrides the whole decode so no memory request leaks out of an aborted access.
        if (reset) begin
            ALUOp      = 4'b0000;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            pc_src     = 2'b00;
            reg_write  = 1'b0;
            reg_dst    = 2'b00;
            mem_to_reg = 2'b00;
            alu_src    = 1'b0;
            illegal_op = 1'b0;
        end
    end

    assign state_out = state;

`ifdef CTRL_PERF_CNT_EN
    logic retire;
    assign retire = (next_state == FETCH) &&
                    ((state == WB) || (state == BRANCH) || (state == JUMP) ||
                     ((state == MEM) && is_sw && mem_ready));

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_retired <= '0;
            stall_cycles  <= '0;
        end else begin
            if (retire)
                instr_retired <= instr_retired + 1'b1;
            if (((state == FETCH) || (state == MEM)) && !mem_ready)
                stall_cycles <= stall_cycles + 1'b1;
        end
    end
`endif

endmodule

// File: doc/multicycle_main_control.md
Name: multicycle_main_control

Overview:
- Upstream stage of the ALU control decoder in the multicycle MIPS core.
- Sequences each instruction through fetch/decode/execute/memory/writeback.
- Produces the 4-bit ALUOp class code consumed by the ALU control decoder, plus all datapath strobes and selects.
- Handles a ready/req memory handshake with stall.

Parameters:
- ILLEGAL_HALT, 0, 1: an illegal opcode parks the FSM in HALT until reset. 0: flag the instruction and continue at FETCH.
- COUNT_W, 32, width of the performance counters (optional feature only).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- opcode  in  6  IR[31:26]; stable from the cycle after ir_write.
- funct  in  6  IR[5:0].
- zero  in  1  ALU zero flag, valid combinationally in BRANCH.
- mem_ready  in  1  memory completes the current read/write this cycle.
- ALUOp  out  4  instruction class code for the ALU control decoder.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  load IR from memory data.
- pc_write  out  1  update PC.
- pc_src  out  2  00 PC+4, 01 branch target, 10 jump target, 11 rs register.
- reg_write  out  1  register file write enable.
- reg_dst  out  2  00 rt, 01 rd, 10 $ra.
- mem_to_reg  out  2  00 ALU result, 01 memory data, 10 PC+4.
- alu_src  out  1  0 register rt, 1 extended immediate.
- state_out  out  3  current state, for debug.
- illegal_op  out  1  one-cycle pulse on an illegal opcode.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high. The state register is Moore; all outputs decode from state plus (opcode, funct, zero, mem_ready).
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, BRANCH=5, JUMP=6, HALT=7.
- While reset=1, every strobe, ALUOp and illegal_op is forced to 0. Next state is FETCH.
- FETCH:
  - mem_read=1.
  - While mem_ready=0: hold, no other strobes.
  - When mem_ready=1: ir_write=1, pc_write=1, pc_src=00, go to DECODE.
- DECODE: classify opcode.
  - 000000 with funct=001000 (JR) -> JUMP.
  - Other R-type, ADDI 001000, ANDI 001100, ORI 001101, LUI 001111, LW 100011, SW 101011 -> EXEC.
  - BEQ 000100 / BNE 000101 -> BRANCH.
  - J 000010 / JAL 000011 -> JUMP.
  - Anything else -> illegal_op=1 for this cycle; next state is HALT if ILLEGAL_HALT=1, else FETCH.
- ALUOp mapping, driven in EXEC, MEM, WB and BRANCH, 0000 in all other states:
  - R-type 0111, ADDI 0100, ANDI 0101, ORI 0110, LUI 0011.
  - BEQ 1000, BNE 1001, LW 1010, SW 1011.
- EXEC:
  - alu_src=0 for R-type, 1 otherwise.
  - LW/SW -> MEM; all others -> WB.
- MEM:
  - LW: mem_read=1. SW: mem_write=1. alu_src=1.
  - Hold while mem_ready=0; no other strobes during the wait.
  - On mem_ready=1: SW -> FETCH, LW -> WB.
- WB: reg_write=1 for exactly one cycle, then FETCH.
  - R-type: reg_dst=01, mem_to_reg=00.
  - I-type ALU ops: reg_dst=00, mem_to_reg=00.
  - LW: reg_dst=00, mem_to_reg=01.
- BRANCH:
  - pc_src=01.
  - pc_write = zero for BEQ, ~zero for BNE.
  - Then FETCH.
- JUMP, then FETCH:
  - J: pc_write=1, pc_src=10.
  - JAL: as J, plus reg_write=1, reg_dst=10, mem_to_reg=10.
  - JR: pc_write=1, pc_src=11, reg_write=0.
- HALT: all strobes 0; sticky until reset.
- Latency with mem_ready tied to 1: R-type and I-type ALU ops 4 cycles; LW 5; SW 4; branch, J, JAL, JR 3. Each memory wait cycle adds 1.
- Reset mid-operation (including during a MEM wait): the reset cycle has mem_read=mem_write=0. The first post-reset cycle is FETCH.
- mem_read and mem_write are never both 1.
- reg_write and pc_write are never asserted in a wait cycle.

Optional Feature:
- Macro CTRL_PERF_CNT_EN.
- Defined: adds outputs instr_retired[COUNT_W-1:0] and stall_cycles[COUNT_W-1:0], both cleared by reset.
  - instr_retired increments on each transition into FETCH from WB, BRANCH, JUMP, or MEM(SW). It does not increment on the illegal-opcode path.
  - stall_cycles increments on every FETCH or MEM cycle with mem_ready=0.
  - Both wrap modulo 2^COUNT_W.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then ADD (opcode 000000, funct 100000) with mem_ready=1 -> state_out 0,1,2,4,0. ALUOp=0111 in EXEC and WB. reg_write=1 and reg_dst=01 only in WB.
- LW with mem_ready=0 for 3 MEM cycles -> mem_read held 4 MEM cycles, ALUOp=1010, then WB with mem_to_reg=01, reg_dst=00; total 8 cycles.
- BEQ with zero=1 -> BRANCH pc_write=1, pc_src=01, ALUOp=1000. BNE with zero=1 -> pc_write=0, ALUOp=1001.
- JAL -> JUMP with pc_src=10, reg_write=1, reg_dst=10, mem_to_reg=10. JR (funct 001000) -> pc_src=11, reg_write=0, 3 cycles.
- Opcode 111111:
  - ILLEGAL_HALT=0 -> single illegal_op pulse in DECODE, FETCH next.
  - ILLEGAL_HALT=1 -> state_out=7 held for 20 cycles with all strobes 0, exits only on reset.
- SW stalled in MEM, reset asserted for 1 cycle -> mem_write=0 in the reset cycle, state_out=0 next cycle. With CTRL_PERF_CNT_EN: instr_retired=0, stall_cycles=0 after reset.
